// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: turns one request into an INCR burst on AR+R or AW+W+B
// and reports completion with a one-cycle done pulse plus an error flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; addr/len captured on acceptance
// AR    | read address presented, waiting for arready
// R     | read beats forwarded to the user, beats counted for LAST check
// AW    | write address presented, waiting for awready
// W     | user write beats forwarded, WLAST generated from the beat count
// B     | waiting for the write response
module axi_burst_master #(
    parameter int AXI_ADDR_W = 64,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 8,
    parameter int MST_ID     = 0
) (
    input  logic                    aclk,
    input  logic                    arst_n,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AXI_ADDR_W-1:0]   req_addr,
    input  logic [7:0]              req_len,

    input  logic                    usr_wvalid,
    output logic                    usr_wready,
    input  logic [AXI_DATA_W-1:0]   usr_wdata,
    input  logic [AXI_DATA_W/8-1:0] usr_wstrb,

    output logic                    usr_rvalid,
    input  logic                    usr_rready,
    output logic [AXI_DATA_W-1:0]   usr_rdata,
    output logic                    usr_rlast,

    output logic                    done,
    output logic                    done_err,

    output logic                    mst_awvalid,
    input  logic                    mst_awready,
    output logic [AXI_ADDR_W-1:0]   mst_awaddr,
    output logic [7:0]              mst_awlen,
    output logic [2:0]              mst_awsize,
    output logic [1:0]              mst_awburst,
    output logic [AXI_ID_W-1:0]     mst_awid,
    output logic                    mst_awlock,
    output logic [3:0]              mst_awcache,
    output logic [2:0]              mst_awprot,
    output logic [3:0]              mst_awqos,
    output logic [3:0]              mst_awregion,

    output logic                    mst_wvalid,
    input  logic                    mst_wready,
    output logic [AXI_DATA_W-1:0]   mst_wdata,
    output logic [AXI_DATA_W/8-1:0] mst_wstrb,
    output logic                    mst_wlast,

    input  logic                    mst_bvalid,
    output logic                    mst_bready,
    input  logic [AXI_ID_W-1:0]     mst_bid,
    input  logic [1:0]              mst_bresp,

    output logic                    mst_arvalid,
    input  logic                    mst_arready,
    output logic [AXI_ADDR_W-1:0]   mst_araddr,
    output logic [7:0]              mst_arlen,
    output logic [2:0]              mst_arsize,
    output logic [1:0]              mst_arburst,
    output logic [AXI_ID_W-1:0]     mst_arid,
    output logic                    mst_arlock,
    output logic [3:0]              mst_arcache,
    output logic [2:0]              mst_arprot,
    output logic [3:0]              mst_arqos,
    output logic [3:0]              mst_arregion,

    input  logic                    mst_rvalid,
    output logic                    mst_rready,
    input  logic [AXI_ID_W-1:0]     mst_rid,
    input  logic [1:0]              mst_rresp,
    input  logic [AXI_DATA_W-1:0]   mst_rdata,
    input  logic                    mst_rlast
);

    localparam int                  LP_SIZE = $clog2(AXI_DATA_W / 8);
    localparam logic [AXI_ID_W-1:0] LP_ID   = AXI_ID_W'(MST_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AXI_ADDR_W-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    r_err;
    logic                    w_err_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_done_err;
    logic                    w_done_err_nxt;
    logic                    w_load;
    logic                    w_beat_err;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_done     <= w_done_nxt;
            r_done_err <= w_done_err_nxt;
            if (w_load) begin
                r_addr <= req_addr;
                r_len  <= req_len;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = r_err;
        w_done_nxt     = 1'b0;
        w_done_err_nxt = 1'b0;
        w_load         = 1'b0;
        w_beat_err     = 1'b0;
        req_ready      = 1'b0;
        usr_wready     = 1'b0;
        usr_rvalid     = 1'b0;
        mst_awvalid    = 1'b0;
        mst_wvalid     = 1'b0;
        mst_wlast      = 1'b0;
        mst_bready     = 1'b0;
        mst_arvalid    = 1'b0;
        mst_rready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = req_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                mst_arvalid = 1'b1;
                if (mst_arready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                mst_rready = usr_rready;
                usr_rvalid = mst_rvalid;
                if (mst_rvalid && usr_rready) begin
                    // A beat whose LAST flag disagrees with the count marks the burst bad.
                    w_beat_err = (mst_rresp != 2'b00) || (mst_rlast != (r_cnt == r_len))
                                 || (mst_rid != LP_ID);
                    w_err_nxt  = r_err | w_beat_err;
                    w_cnt_nxt  = r_cnt + 8'd1;
                    if (mst_rlast) begin
                        w_state_nxt    = S_IDLE;
                        w_done_nxt     = 1'b1;
                        w_done_err_nxt = r_err | w_beat_err;
                    end
                end
            end
            S_AW: begin
                mst_awvalid = 1'b1;
                if (mst_awready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_W;
                end
            end
            S_W: begin
                mst_wvalid = usr_wvalid;
                usr_wready = mst_wready;
                mst_wlast  = (r_cnt == r_len);
                if (usr_wvalid && mst_wready) begin
                    if (r_cnt == r_len) begin
                        w_state_nxt = S_B;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_B: begin
                mst_bready = 1'b1;
                if (mst_bvalid) begin
                    w_beat_err     = (mst_bresp != 2'b00) || (mst_bid != LP_ID);
                    w_err_nxt      = r_err | w_beat_err;
                    w_state_nxt    = S_IDLE;
                    w_done_nxt     = 1'b1;
                    w_done_err_nxt = r_err | w_beat_err;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign done         = r_done;
    assign done_err     = r_done_err;

    assign usr_rdata    = mst_rdata;
    assign usr_rlast    = mst_rlast;
    assign mst_wdata    = usr_wdata;
    assign mst_wstrb    = usr_wstrb;

    assign mst_awaddr   = r_addr;
    assign mst_awlen    = r_len;
    assign mst_awsize   = 3'(LP_SIZE);
    assign mst_awburst  = 2'b01;
    assign mst_awid     = LP_ID;
    assign mst_awlock   = 1'b0;
    assign mst_awcache  = 4'h0;
    assign mst_awprot   = 3'h0;
    assign mst_awqos    = 4'h0;
    assign mst_awregion = 4'h0;

    assign mst_araddr   = r_addr;
    assign mst_arlen    = r_len;
    assign mst_arsize   = 3'(LP_SIZE);
    assign mst_arburst  = 2'b01;
    assign mst_arid     = LP_ID;
    assign mst_arlock   = 1'b0;
    assign mst_arcache  = 4'h0;
    assign mst_arprot   = 3'h0;
    assign mst_arqos    = 4'h0;
    assign mst_arregion = 4'h0;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: the bench plays both requester and AXI slave, and derives
// expected beats, LAST placement and the error flag from each burst's description.
module tb_axi_burst_master;

    logic        aclk;
    logic        arst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic        usr_wvalid;
    logic        usr_wready;
    logic [63:0] usr_wdata;
    logic [7:0]  usr_wstrb;
    logic        usr_rvalid;
    logic        usr_rready;
    logic [63:0] usr_rdata;
    logic        usr_rlast;
    logic        done;
    logic        done_err;
    logic        mst_awvalid, mst_awready;
    logic [63:0] mst_awaddr;
    logic [7:0]  mst_awlen;
    logic [2:0]  mst_awsize;
    logic [1:0]  mst_awburst;
    logic [7:0]  mst_awid;
    logic        mst_awlock;
    logic [3:0]  mst_awcache;
    logic [2:0]  mst_awprot;
    logic [3:0]  mst_awqos;
    logic [3:0]  mst_awregion;
    logic        mst_wvalid, mst_wready;
    logic [63:0] mst_wdata;
    logic [7:0]  mst_wstrb;
    logic        mst_wlast;
    logic        mst_bvalid, mst_bready;
    logic [7:0]  mst_bid;
    logic [1:0]  mst_bresp;
    logic        mst_arvalid, mst_arready;
    logic [63:0] mst_araddr;
    logic [7:0]  mst_arlen;
    logic [2:0]  mst_arsize;
    logic [1:0]  mst_arburst;
    logic [7:0]  mst_arid;
    logic        mst_arlock;
    logic [3:0]  mst_arcache;
    logic [2:0]  mst_arprot;
    logic [3:0]  mst_arqos;
    logic [3:0]  mst_arregion;
    logic        mst_rvalid, mst_rready;
    logic [7:0]  mst_rid;
    logic [1:0]  mst_rresp;
    logic [63:0] mst_rdata;
    logic        mst_rlast;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rd_data [0:299];
    logic [63:0] t_addr;
    int          t_len, t_mode, t_last, t_errb;
    logic [1:0]  t_bresp;

    axi_burst_master dut (
        .aclk(aclk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_wdata(usr_wdata),
        .usr_wstrb(usr_wstrb),
        .usr_rvalid(usr_rvalid), .usr_rready(usr_rready), .usr_rdata(usr_rdata),
        .usr_rlast(usr_rlast),
        .done(done), .done_err(done_err),
        .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awaddr(mst_awaddr),
        .mst_awlen(mst_awlen), .mst_awsize(mst_awsize), .mst_awburst(mst_awburst),
        .mst_awid(mst_awid), .mst_awlock(mst_awlock), .mst_awcache(mst_awcache),
        .mst_awprot(mst_awprot), .mst_awqos(mst_awqos), .mst_awregion(mst_awregion),
        .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wdata(mst_wdata),
        .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast),
        .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bid(mst_bid),
        .mst_bresp(mst_bresp),
        .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_araddr(mst_araddr),
        .mst_arlen(mst_arlen), .mst_arsize(mst_arsize), .mst_arburst(mst_arburst),
        .mst_arid(mst_arid), .mst_arlock(mst_arlock), .mst_arcache(mst_arcache),
        .mst_arprot(mst_arprot), .mst_arqos(mst_arqos), .mst_arregion(mst_arregion),
        .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rid(mst_rid),
        .mst_rresp(mst_rresp), .mst_rdata(mst_rdata), .mst_rlast(mst_rlast)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_awvalid"}, 64'(mst_awvalid), 64'd0);
        chk({tag, "_wvalid"},  64'(mst_wvalid),  64'd0);
        chk({tag, "_arvalid"}, 64'(mst_arvalid), 64'd0);
        chk({tag, "_bready"},  64'(mst_bready),  64'd0);
        chk({tag, "_rready"},  64'(mst_rready),  64'd0);
        chk({tag, "_uwready"}, 64'(usr_wready),  64'd0);
        chk({tag, "_urvalid"}, 64'(usr_rvalid),  64'd0);
        chk({tag, "_done"},    64'(done),        64'd0);
    endtask

    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [7:0] len);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        #1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge aclk); #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_len   = 8'($urandom);
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input int last_at,
                           input int err_beat, input logic [7:0] rid, input bit toggle,
                           input logic [63:0] d0);
        int nb, k, i, cyc;
        bit exp_err, sv, ur, held, prev_sv;
        nb = last_at + 1;
        for (int b = 0; b < nb; b++) rd_data[b] = (b == 0) ? d0 : {$urandom, $urandom};
        exp_err = (last_at != len) || (err_beat >= 0 && err_beat < nb) || (rid != 8'd0);
        do_req(1'b0, addr, 8'(len));
        k = $urandom_range(0, 2);
        usr_rready = 1'b1;
        for (int c = 0; c <= k; c++) begin
            mst_arready = (c == k);
            #1;
            chk("ar_valid", 64'(mst_arvalid), 64'd1);
            chk("ar_addr",  mst_araddr, addr);
            chk("ar_len",   64'(mst_arlen), 64'(len));
            chk("ar_size",  64'(mst_arsize), 64'd3);
            chk("ar_burst", 64'(mst_arburst), 64'd1);
            chk("ar_id",    64'(mst_arid), 64'd0);
            chk("ar_rready", 64'(mst_rready), 64'd0);
            chk("ar_awvalid", 64'(mst_awvalid), 64'd0);
            @(posedge aclk); #1;
        end
        mst_arready = 1'b0;
        i = 0; cyc = 0; held = 1'b0; prev_sv = 1'b0;
        while (i < nb && cyc < 4000) begin
            if (held) sv = 1'b1;
            else if (toggle) sv = !prev_sv;
            else sv = ($urandom_range(0, 3) != 0);
            ur = toggle ? ((cyc % 2) == 1) : ($urandom_range(0, 3) != 0);
            mst_rvalid = sv;
            mst_rdata  = rd_data[i];
            mst_rlast  = (i == last_at);
            mst_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            mst_rid    = rid;
            usr_rready = ur;
            #1;
            chk("r_urvalid", 64'(usr_rvalid), 64'(sv));
            chk("r_rready",  64'(mst_rready), 64'(ur));
            chk("r_done_low", 64'(done), 64'd0);
            if (sv) begin
                chk("r_data", usr_rdata, rd_data[i]);
                chk("r_last", 64'(usr_rlast), 64'(i == last_at));
            end
            @(posedge aclk); #1;
            prev_sv = sv;
            if (sv && ur) begin
                i++;
                held = 1'b0;
            end else begin
                held = sv;
            end
            cyc++;
        end
        chk("r_beats_in_budget", 64'(i), 64'(nb));
        mst_rvalid = 1'b0;
        mst_rlast  = 1'b0;
        usr_rready = 1'b0;
        #1;
        chk("r_done",     64'(done), 64'd1);
        chk("r_done_err", 64'(done_err), 64'(exp_err));
        chk("r_idle_ready", 64'(req_ready), 64'd1);
        @(posedge aclk); #1;
        chk("r_done_pulse", 64'(done), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] bresp,
                            input logic [7:0] bid, input bit strb_ff, input int rst_at);
        int k, i, cyc, n_last;
        bit exp_err, uv, wr, hs;
        logic [63:0] wd;
        logic [7:0]  ws;
        exp_err = (bresp != 2'b00) || (bid != 8'd0);
        do_req(1'b1, addr, 8'(len));
        k = $urandom_range(0, 2);
        usr_wvalid = 1'b1;
        mst_wready = 1'b1;
        for (int c = 0; c <= k; c++) begin
            mst_awready = (c == k);
            #1;
            chk("aw_valid", 64'(mst_awvalid), 64'd1);
            chk("aw_addr",  mst_awaddr, addr);
            chk("aw_len",   64'(mst_awlen), 64'(len));
            chk("aw_size",  64'(mst_awsize), 64'd3);
            chk("aw_burst", 64'(mst_awburst), 64'd1);
            chk("aw_id",    64'(mst_awid), 64'd0);
            chk("aw_no_w",  64'(mst_wvalid), 64'd0);
            chk("aw_uwready", 64'(usr_wready), 64'd0);
            @(posedge aclk); #1;
        end
        mst_awready = 1'b0;
        usr_wvalid  = 1'b0;
        mst_wready  = 1'b0;
        i = 0; cyc = 0; uv = 1'b0; n_last = 0; wd = '0; ws = '0;
        while (i <= len && cyc < 4000) begin
            if (i == rst_at) begin
                usr_wvalid = 1'b1;
                mst_wready = 1'b0;
                #1;
                arst_n = 1'b0;
                #1;
                chk_all_idle("rst_async");
                @(posedge aclk); #1;
                chk_all_idle("rst_edge");
                arst_n = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(posedge aclk); #1;
                    chk("rst_no_done", 64'(done), 64'd0);
                    chk("rst_wvalid",  64'(mst_wvalid), 64'd0);
                    chk("rst_idle",    64'(req_ready), 64'd1);
                end
                usr_wvalid = 1'b0;
                return;
            end
            if (!uv) begin
                uv = ($urandom_range(0, 3) != 0);
                wd = {$urandom, $urandom};
                ws = strb_ff ? 8'hFF : 8'($urandom);
            end
            wr = ($urandom_range(0, 2) != 0);
            usr_wvalid = uv;
            usr_wdata  = wd;
            usr_wstrb  = ws;
            mst_wready = wr;
            #1;
            chk("w_valid",  64'(mst_wvalid), 64'(uv));
            chk("w_uready", 64'(usr_wready), 64'(wr));
            chk("w_bready", 64'(mst_bready), 64'd0);
            if (uv) begin
                chk("w_data", mst_wdata, wd);
                chk("w_strb", 64'(mst_wstrb), 64'(ws));
                chk("w_last", 64'(mst_wlast), 64'(i == len));
            end
            hs = uv && wr;
            if (hs && mst_wlast) n_last++;
            @(posedge aclk); #1;
            if (hs) begin
                i++;
                uv = 1'b0;
            end
            cyc++;
        end
        chk("w_beats_in_budget", 64'(i), 64'(len + 1));
        chk("w_one_last", 64'(n_last), 64'd1);
        usr_wvalid = 1'b0;
        mst_wready = 1'b0;
        k = $urandom_range(0, 2);
        for (int c = 0; c <= k; c++) begin
            mst_bvalid = (c == k);
            mst_bresp  = bresp;
            mst_bid    = bid;
            #1;
            chk("b_ready",  64'(mst_bready), 64'd1);
            chk("b_wvalid", 64'(mst_wvalid), 64'd0);
            chk("b_done_low", 64'(done), 64'd0);
            @(posedge aclk); #1;
        end
        mst_bvalid = 1'b0;
        #1;
        chk("b_done",     64'(done), 64'd1);
        chk("b_done_err", 64'(done_err), 64'(exp_err));
        chk("b_idle_ready", 64'(req_ready), 64'd1);
        @(posedge aclk); #1;
        chk("b_done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        arst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        usr_wvalid = 1'b0; usr_wdata = '0; usr_wstrb = '0; usr_rready = 1'b0;
        mst_awready = 1'b0; mst_wready = 1'b0; mst_bvalid = 1'b0; mst_bid = '0;
        mst_bresp = '0; mst_arready = 1'b0; mst_rvalid = 1'b0; mst_rid = '0;
        mst_rresp = '0; mst_rdata = '0; mst_rlast = 1'b0;
        #1 arst_n = 1'b0;
        #2;
        chk_all_idle("reset");
        chk("reset_done_err", 64'(done_err), 64'd0);
        chk("reset_tie_awcache", 64'(mst_awcache), 64'd0);
        chk("reset_tie_arprot",  64'(mst_arprot), 64'd0);
        #19 arst_n = 1'b1;
        @(posedge aclk); #1;
        chk("post_reset_ready", 64'(req_ready), 64'd1);

        do_read(64'h8000_0000, 0, 0, -1, 8'd0, 1'b0, 64'h1122);
        do_write(64'h8000_0040, 3, 2'b00, 8'd0, 1'b1, -1);
        do_read(64'h8000_0100, 7, 7, -1, 8'd0, 1'b1, {$urandom, $urandom});
        do_write(64'h8000_0200, 2, 2'b10, 8'd0, 1'b0, -1);
        do_read(64'h8000_0300, 1, 1, -1, 8'd0, 1'b0, {$urandom, $urandom});
        do_read(64'h8000_0400, 3, 2, -1, 8'd0, 1'b0, {$urandom, $urandom});
        do_write(64'h8000_0500, 3, 2'b00, 8'd0, 1'b0, 1);
        do_read(64'h8000_0600, 2, 2, -1, 8'd0, 1'b0, {$urandom, $urandom});
        do_read(64'h8000_0700, 2, 4, -1, 8'd0, 1'b0, {$urandom, $urandom});
        do_read(64'h8000_0800, 1, 1, -1, 8'd5, 1'b0, {$urandom, $urandom});
        do_write(64'h8000_0900, 0, 2'b00, 8'd7, 1'b0, -1);
        do_write(64'h8000_0A00, 0, 2'b00, 8'd0, 1'b0, -1);
        do_read(64'h8000_1000, 255, 255, -1, 8'd0, 1'b0, {$urandom, $urandom});
        do_write(64'h8000_2000, 255, 2'b00, 8'd0, 1'b0, -1);

        for (int t = 0; t < 20; t++) begin
            t_addr = {$urandom, $urandom};
            t_addr[2:0] = 3'b000;
            t_len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                t_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                do_write(t_addr, t_len, t_bresp, 8'd0, 1'b0, -1);
            end else begin
                t_mode = $urandom_range(0, 5);
                t_last = t_len;
                t_errb = -1;
                if (t_mode == 0 && t_len > 0) t_last = $urandom_range(0, t_len - 1);
                if (t_mode == 1) t_last = t_len + $urandom_range(1, 2);
                if (t_mode == 2) t_errb = $urandom_range(0, t_len);
                do_read(t_addr, t_len, t_last, t_errb, 8'd0, 1'($urandom_range(0, 1)),
                        {$urandom, $urandom});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
